// File: rtl/binary_tower_pkg.sv
// Shared types and helpers for the GF(2^32) binary tower blocks.
// Holds the field width, the Frobenius FSM states and a round-robin pick.
package binary_tower_pkg;

  localparam int GF32_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    DONE = 2'd2
  } frob_state_t;

  // First set bit of req[n-1:0], searching upward from ptr with wrap.
  // Returns ptr when nothing is set; callers qualify with |req.
  function automatic int unsigned rr_next(
    input logic [31:0] req,
    input int unsigned ptr,
    input int unsigned n
  );
    int unsigned g;
    int unsigned j;
    logic        f;
    g = ptr;
    f = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      j = (ptr + i) % n;
      if (i < n && !f && req[j[4:0]]) begin
        g = j;
        f = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/binary_tower_32b_sqr.sv
// Combinational squarer in the GF(2^32) binary tower field.
// Ports: ap_ce/ap_rst qualify the output, a in, ap_return = a^2.
module binary_tower_32b_sqr
  import binary_tower_pkg::*;
(
  input  logic              ap_ce,
  input  logic              ap_rst,
  input  logic [GF32_W-1:0] a,
  output logic [GF32_W-1:0] ap_return
);

  // Tower: level j adds x_j with x_j^2 = x_{j-1}*x_j + 1, x_{-1} = 1.
  // Multiply a 2^m-bit element by the generator of its own level.
  // Only the chain of upper halves needs the recursive step, so it is
  // evaluated bottom-up from the top bit.
  function automatic logic [31:0] mulx(
    input logic [31:0] v,
    input int          m
  );
    logic [31:0] cur;
    logic [31:0] x;
    logic [31:0] l;
    logic [31:0] h;
    int          w;
    int          wj;
    w   = 1 << m;
    cur = (v >> (w - 1)) & 32'd1;
    for (int j = 1; j <= 5; j++) begin
      if (j <= m) begin
        wj  = 1 << j;
        x   = v >> (w - wj);
        l   = x & ((32'd1 << (wj / 2)) - 32'd1);
        h   = x >> (wj / 2);
        cur = ((l ^ cur) << (wj / 2)) | h;
      end
    end
    return cur;
  endfunction

  // (l + h*y)^2 = (l^2 + h^2) + (h^2 * x_prev) * y, all chunks per level.
  function automatic logic [31:0] tower_sq(input logic [31:0] v);
    logic [31:0] s;
    logic [31:0] ch;
    logic [31:0] l;
    logic [31:0] h;
    logic [31:0] lm;
    logic [31:0] cm;
    logic [31:0] nc;
    int          w;
    int          hw;
    int          off;
    s = v;
    for (int m = 1; m <= 5; m++) begin
      w  = 1 << m;
      hw = w / 2;
      lm = (32'd1 << hw) - 32'd1;
      cm = (m == 5) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
      for (int c = 0; c < 16; c++) begin
        if (c < (32 >> m)) begin
          off = c * w;
          ch  = (s >> off) & cm;
          l   = ch & lm;
          h   = ch >> hw;
          nc  = (l ^ h) | (mulx(h, m - 1) << hw);
          s   = (s & ~(cm << off)) | (nc << off);
        end
      end
    end
    return s;
  endfunction

  always_comb begin
    ap_return = '0;
    if (ap_ce && !ap_rst) ap_return = tower_sq(a);
  end

endmodule

// File: rtl/binary_tower_32b_frob_arb.sv
// Round-robin shared sequencer computing a^(2^k) on one tower squarer.
// Ports: req_* per-requester handshake, resp_* tagged result handshake.
module binary_tower_32b_frob_arb
  import binary_tower_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int K_W     = 5,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*GF32_W-1:0] req_a,
  input  logic [NUM_REQ*K_W-1:0]    req_k,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [GF32_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id
);

  frob_state_t       r_state;
  frob_state_t       w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [GF32_W-1:0] r_acc;
  logic [K_W-1:0]    r_cnt;

  logic [ID_W-1:0]   w_grant;
  logic              w_any;
  logic              w_accept;
  logic [GF32_W-1:0] w_a;
  logic [K_W-1:0]    w_k;
  logic [GF32_W-1:0] w_sq;
  logic [ID_W-1:0]   w_id_inc;

  assign w_grant = ID_W'(rr_next(32'(req_valid), 32'(r_rr_ptr),
                                 NUM_REQ));
  assign w_any    = |req_valid;
  assign w_accept = (r_state == IDLE) && w_any;
  assign w_a      = req_a[int'(w_grant) * GF32_W +: GF32_W];
  assign w_k      = req_k[int'(w_grant) * K_W +: K_W];

  assign w_id_inc = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  // Grant only the winner; nothing while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (w_accept && !ap_rst) req_ready = NUM_REQ'(1) << w_grant;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = (w_k == '0) ? DONE : SQR;
      end
      SQR: begin
        if (r_cnt == K_W'(1)) w_state_nxt = DONE;
      end
      DONE: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= w_a;
            r_cnt <= w_k;
            r_id  <= w_grant;
          end
        end
        SQR: begin
          r_acc <= w_sq;
          r_cnt <= r_cnt - 1'b1;
        end
        DONE: begin
          if (resp_ready) r_rr_ptr <= w_id_inc;
        end
        default: ;
      endcase
    end
  end

  binary_tower_32b_sqr u_sqr (
    .ap_ce     (1'b1),
    .ap_rst    (ap_rst),
    .a         (r_acc),
    .ap_return (w_sq)
  );

  assign resp_valid = (r_state == DONE);
  assign resp_data  = r_acc;
  assign resp_id    = r_id;

endmodule

// File: tb/tb_binary_tower_32b_frob_arb.sv
// Self-checking bench for binary_tower_32b_frob_arb.
// Field model built from the tower relations; transaction-level timing model.
module tb_binary_tower_32b_frob_arb;

  localparam int N  = 4;
  localparam int KW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*KW-1:0] req_k;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [1:0]      resp_id;

  binary_tower_32b_frob_arb #(.NUM_REQ(N), .K_W(KW)) dut (
    .ap_clk     (clk),
    .ap_rst     (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_k      (req_k),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // ---------------- field model ----------------
  // Element = XOR of monomials; bit b stands for prod of x_j, j in b.
  // x_j^2 = x_{j-1} x_j + 1 with x_{-1} = 1.
  logic [31:0] sqtab [32];

  function automatic logic [31:0] mono_xi(input int b, input int i);
    logic [31:0] r;
    int          j;
    if (((b >> i) & 1) == 0) return 32'd1 << (b | (1 << i));
    r = 0;
    j = i;
    while (j >= 0 && ((b >> j) & 1) == 1) begin
      r ^= 32'd1 << (b ^ (1 << j));
      j--;
    end
    if (j < 0) r ^= 32'd1 << b;
    else       r ^= 32'd1 << (b | (1 << j));
    return r;
  endfunction

  function automatic logic [31:0] mul_xi(input logic [31:0] e, input int i);
    logic [31:0] r;
    r = 0;
    for (int b = 0; b < 32; b++) if (e[b]) r ^= mono_xi(b, i);
    return r;
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] e,
                                       input logic [31:0] f);
    logic [31:0] r;
    logic [31:0] p;
    r = 0;
    for (int t = 0; t < 32; t++) begin
      if (f[t]) begin
        p = e;
        for (int i = 0; i < 5; i++) if (((t >> i) & 1) == 1) p = mul_xi(p, i);
        r ^= p;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] fsq(input logic [31:0] e);
    logic [31:0] r;
    r = 0;
    for (int b = 0; b < 32; b++) if (e[b]) r ^= sqtab[b];
    return r;
  endfunction

  function automatic logic [31:0] frob(input logic [31:0] a, input int k);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < k; i++) r = fsq(r);
    return r;
  endfunction

  // ---------------- transaction model + compare ----------------
  logic        m_busy = 1'b0;
  int          m_ptr = 0;
  int          m_due = 0;
  int          m_id = 0;
  logic [31:0] m_data = 0;
  logic [N-1:0] e_rdy;
  logic        e_v;
  int          g;
  logic [4:0]  gk;

  int          acc_cnt = 0;
  int          resp_cnt = 0;
  int          last_acc_cyc = 0;
  int          last_acc_id = 0;
  int          last_resp_cyc = 0;
  int          last_resp_id = 0;
  int          first_v_cyc = 0;
  logic [31:0] last_resp_data = 0;
  logic        prev_rv = 1'b0;
  int          acc_ids[$];
  int          acc_cycs[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_id", 32'(resp_id), 0);
      m_busy  = 1'b0;
      m_ptr   = 0;
      prev_rv = 1'b0;
    end else begin
      e_rdy = '0;
      g = -1;
      if (!m_busy)
        for (int i = 0; i < N; i++)
          if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      if (g >= 0) e_rdy[g] = 1'b1;
      e_v = m_busy && (cyc >= m_due);
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(e_v));
      if (e_v) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_id", 32'(resp_id), 32'(m_id));
      end
      if (resp_valid && !prev_rv) first_v_cyc = cyc;
      prev_rv = resp_valid;
      for (int j = 0; j < N; j++) begin
        if (req_ready[j] && req_valid[j]) begin
          acc_cnt++;
          last_acc_cyc = cyc;
          last_acc_id  = j;
          acc_ids.push_back(j);
          acc_cycs.push_back(cyc);
        end
      end
      if (resp_valid && resp_ready) begin
        resp_cnt++;
        last_resp_cyc  = cyc;
        last_resp_data = resp_data;
        last_resp_id   = int'(resp_id);
      end
      if (e_v && resp_ready) begin
        m_busy = 1'b0;
        m_ptr  = (m_id + 1) % N;
      end
      if (g >= 0) begin
        gk     = req_k[KW*g +: KW];
        m_busy = 1'b1;
        m_id   = g;
        m_due  = cyc + 1 + int'(gk);
        m_data = frob(req_a[32*g +: 32], int'(gk));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int target, input int budget);
    for (int i = 0; i < budget && acc_cnt < target; i++) tick(1);
    chk("accept_timeout", 32'(acc_cnt >= target), 1);
  endtask

  task automatic wait_resp(input int target, input int budget);
    for (int i = 0; i < budget && resp_cnt < target; i++) tick(1);
    chk("resp_timeout", 32'(resp_cnt >= target), 1);
  endtask

  task automatic wait_rv(input int budget);
    for (int i = 0; i < budget && !resp_valid; i++) tick(1);
    chk("resp_valid_timeout", 32'(resp_valid), 1);
  endtask

  task automatic set_req(input int id, input logic [31:0] a,
                         input logic [4:0] k);
    req_a[32*id +: 32] = a;
    req_k[KW*id +: KW] = k;
  endtask

  task automatic run_op(input int id, input logic [31:0] a,
                        input logic [4:0] k, output logic [31:0] d);
    int a0;
    int r0;
    a0 = acc_cnt;
    r0 = resp_cnt;
    set_req(id, a, k);
    req_valid[id] = 1'b1;
    wait_acc(a0 + 1, 40);
    req_valid[id] = 1'b0;
    wait_resp(r0 + 1, 80);
    d = last_resp_data;
  endtask

  logic [31:0] d;
  logic [31:0] d2;
  logic [31:0] a;
  logic [31:0] hold_d;
  logic [1:0]  hold_id;
  logic [4:0]  k;
  int          id;
  int          a0;
  int          r0;
  int          q0;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_k      = '0;
    resp_ready = 1'b1;

    for (int b = 0; b < 32; b++)
      sqtab[b] = fmul(32'd1 << b, 32'd1 << b);
    chk("model_sq_x0", fsq(32'h2), 32'h3);
    chk("model_sq_x1", fsq(32'h4), 32'h9);
    chk("model_inv_x0", fmul(32'h2, 32'h3), 32'h1);

    tick(3);
    rst = 1'b0;
    tick(2);

    run_op(2, 32'h2, 5'd1, d);
    chk("k1_data", d, 32'h3);
    chk("k1_id", 32'(last_resp_id), 2);
    chk("k1_latency", 32'(first_v_cyc - last_acc_cyc), 2);
    run_op(2, 32'h2, 5'd2, d);
    chk("k2_data", d, 32'h2);
    chk("k2_latency", 32'(first_v_cyc - last_acc_cyc), 3);
    run_op(2, 32'h2, 5'd0, d);
    chk("k0_data", d, 32'h2);
    chk("k0_latency", 32'(first_v_cyc - last_acc_cyc), 1);
    run_op(1, 32'h4, 5'd1, d);
    chk("x1_sq_data", d, 32'h9);
    run_op(3, 32'h1, 5'd3, d);
    chk("one_fixed", d, 32'h1);

    // round robin, pointer now 0
    for (int i = 0; i < N; i++) set_req(i, 32'(i + 5), 5'd3);
    q0 = acc_ids.size();
    r0 = resp_cnt;
    req_valid = '1;
    wait_acc(acc_cnt + 5, 60);
    req_valid = '0;
    wait_resp(r0 + 5, 60);
    for (int i = 0; i < 5; i++)
      chk("rr_order", 32'(acc_ids[q0 + i]), 32'(i % N));
    for (int i = 1; i < 5; i++)
      chk("rr_spacing", 32'(acc_cycs[q0 + i] - acc_cycs[q0 + i - 1]), 5);
    chk("rr_latency", 32'(first_v_cyc - last_acc_cyc), 4);

    // backpressure
    resp_ready = 1'b0;
    a0 = acc_cnt;
    r0 = resp_cnt;
    set_req(1, 32'h1234_5678, 5'd2);
    req_valid[1] = 1'b1;
    wait_acc(a0 + 1, 20);
    req_valid = 4'b1001;
    wait_rv(20);
    hold_d  = resp_data;
    hold_id = resp_id;
    chk("bp_data", hold_d, frob(32'h1234_5678, 2));
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_hold_data", resp_data, hold_d);
      chk("bp_hold_id", 32'(resp_id), 32'(hold_id));
      chk("bp_req_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    wait_acc(a0 + 2, 20);
    req_valid = '0;
    chk("bp_next_accept", 32'(last_acc_cyc - last_resp_cyc), 1);
    chk("bp_next_id", 32'(last_acc_id), 3);
    wait_resp(r0 + 2, 60);

    // Frobenius order: 32 squarings is the identity
    a = $urandom;
    run_op(0, a, 5'd31, d);
    run_op(1, d, 5'd1, d2);
    chk("frob_order", d2, a);

    // reset while stalled in DONE with every requester valid
    resp_ready = 1'b0;
    a0 = acc_cnt;
    set_req(2, 32'hdead_beef, 5'd4);
    req_valid[2] = 1'b1;
    wait_acc(a0 + 1, 20);
    req_valid[2] = 1'b0;
    wait_rv(20);
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + 32'(i), 5'd2);
    req_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_resp_valid", 32'(resp_valid), 0);
    chk("arst_resp_data", resp_data, 0);
    chk("arst_resp_id", 32'(resp_id), 0);
    tick(1);
    rst = 1'b0;
    resp_ready = 1'b1;
    a0 = acc_cnt;
    r0 = resp_cnt;
    wait_acc(a0 + 1, 10);
    req_valid = '0;
    chk("arst_first_grant", 32'(last_acc_id), 0);
    wait_resp(r0 + 1, 20);
    chk("arst_first_data", last_resp_data, frob(32'h100, 2));

    // reset during SQR discards the operation
    a0 = acc_cnt;
    set_req(2, 32'hcafe_f00d, 5'd20);
    req_valid[2] = 1'b1;
    wait_acc(a0 + 1, 20);
    req_valid[2] = 1'b0;
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    chk("sqr_rst_resp_valid", 32'(resp_valid), 0);
    tick(1);
    rst = 1'b0;
    r0 = resp_cnt;
    tick(30);
    chk("sqr_rst_no_resp", 32'(resp_cnt), 32'(r0));
    run_op(3, 32'h0bad_1dea, 5'd7, d);
    chk("after_rst_data", d, frob(32'h0bad_1dea, 7));

    // random operations against the field model
    for (int n = 0; n < 1000; n++) begin
      id = int'($urandom_range(N - 1, 0));
      a  = $urandom;
      k  = 5'($urandom_range(31, 0));
      run_op(id, a, k, d);
      chk("rand_data", d, frob(a, int'(k)));
    end

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
